// File: rtl/kulisch_pkg.sv
// -----------------------------------------------------------------------------
// kulisch_pkg
// Shared constants and helpers for the Kulisch-style accumulation datapath.
// The float-to-linear-fixed converter and the accumulator both take their
// default widths from here, so the two stages always agree on the format of
// a linear fixed-point term.
//
// Contents:
//   CONV_NON_FRAC / CONV_FRAC / CONV_GUARD : default term format and headroom
//   calc_in_w()   : width of one signed term (sign + integer + fraction)
//   calc_acc_w()  : width of the accumulator (term width + guard bits)
//   sat_inc()     : increment that sticks at all-ones for a given width
//   out_state_t   : states of the result register
// -----------------------------------------------------------------------------
package kulisch_pkg;

   // Term format produced by the float-to-linear-fixed converter
   localparam int CONV_NON_FRAC = 17;
   localparam int CONV_FRAC     = 16;
   localparam int CONV_GUARD    = 8;

   // Widest counter sat_inc can handle
   localparam int SAT_MAX_W = 64;

   // Result register occupancy
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   // Width of one two's-complement term: sign bit + integer + fraction
   function automatic int calc_in_w(input int non_frac, input int frac);
      return 1 + non_frac + frac;
   endfunction

   // Accumulator width: one term plus headroom for carries across a group
   function automatic int calc_acc_w(input int non_frac, input int frac,
                                     input int guard);
      return calc_in_w(non_frac, frac) + guard;
   endfunction

   // Adds one unless the low 'width' bits already hold the all-ones value,
   // in which case the count sticks there instead of wrapping to zero.
   function automatic logic [SAT_MAX_W-1:0] sat_inc(
      input logic [SAT_MAX_W-1:0] value,
      input int unsigned          width
   );
      logic [SAT_MAX_W-1:0] all_ones;
      if (width >= SAT_MAX_W) begin
         all_ones = '1;
      end else begin
         all_ones = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
      end
      return (value == all_ones) ? value : value + SAT_MAX_W'(1);
   endfunction

endpackage

// File: rtl/kulisch_overflow_adder.sv
// -----------------------------------------------------------------------------
// kulisch_overflow_adder
// Combinational W-bit two's-complement adder that wraps modulo 2^W and flags
// signed overflow. Also used by the multi-lane reduction stages.
//
// Parameters:
//   W    : operand and result width
// Ports:
//   a    in  W : first operand
//   b    in  W : second operand
//   sum  out W : a + b modulo 2^W
//   ovf  out 1 : operands share a sign and the sum's sign differs
// -----------------------------------------------------------------------------
module kulisch_overflow_adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   // Signed overflow can only happen when both operands have the same sign,
   // and shows up as the wrapped sum landing on the opposite sign.
   always_comb begin
      sum = a + b;
      ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
   end

endmodule

// File: rtl/linear_fixed_accumulator.sv
// -----------------------------------------------------------------------------
// linear_fixed_accumulator
// Exact (Kulisch-style) summation of a stream of linear fixed-point terms.
// Terms of a group are added into a widened running register; the beat
// marked last moves the total into a one-entry result register together with
// sticky infinity/overflow flags and a saturating term count.
//
// Parameters:
//   ACC_NON_FRAC : integer bits per term, excluding sign
//   ACC_FRAC     : fractional bits per term
//   GUARD        : headroom bits above the term width
//   COUNT_BITS   : width of the term counter
// Ports:
//   clock         in  1          rising-edge clock
//   resetn        in  1          asynchronous active-low reset
//   in_valid      in  1          input beat present
//   in_ready      out 1          beat accepted this cycle if in_valid
//   in_bits       in  IN_W       two's-complement term
//   in_isInf      in  1          term is infinite
//   in_last       in  1          final term of the group
//   out_valid     out 1          result register holds an unconsumed result
//   out_ready     in  1          consumer takes the result
//   out_bits      out ACC_W      two's-complement group sum
//   out_isInf     out 1          some term of the group was infinite
//   out_overflow  out 1          signed overflow of ACC_W within the group
//   out_count     out COUNT_BITS terms in the group, saturating
// -----------------------------------------------------------------------------
module linear_fixed_accumulator
   import kulisch_pkg::*;
#(
   parameter  int ACC_NON_FRAC = CONV_NON_FRAC,
   parameter  int ACC_FRAC     = CONV_FRAC,
   parameter  int GUARD        = CONV_GUARD,
   parameter  int COUNT_BITS   = 16,
   localparam int IN_W         = calc_in_w(ACC_NON_FRAC, ACC_FRAC),
   localparam int ACC_W        = calc_acc_w(ACC_NON_FRAC, ACC_FRAC, GUARD)
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       in_bits,
   input  logic                  in_isInf,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      out_bits,
   output logic                  out_isInf,
   output logic                  out_overflow,
   output logic [COUNT_BITS-1:0] out_count
);

   out_state_t            state;
   out_state_t            next_state;

   logic [ACC_W-1:0]      acc;
   logic                  inf_s;
   logic                  ovf_s;
   logic [COUNT_BITS-1:0] cnt;

   logic                  accept;
   logic                  accept_last;
   logic [ACC_W-1:0]      term_ext;
   logic [ACC_W-1:0]      sum;
   logic                  ovf;
   logic                  next_inf;
   logic                  next_ovf;
   logic [COUNT_BITS-1:0] next_cnt;

   // Readiness depends only on the result register, never on the incoming
   // beat, so an upstream stage can use it without a combinational loop.
   assign out_valid   = (state == OUT_FULL);
   assign in_ready    = !out_valid || out_ready;
   assign accept      = in_valid && in_ready;
   assign accept_last = accept && in_last;

   // A signed cast followed by a size cast sign-extends, and still works
   // when GUARD is zero and no extension bits are needed.
   assign term_ext = ACC_W'($signed(in_bits));

   kulisch_overflow_adder #(
      .W (ACC_W)
   ) u_adder (
      .a   (acc),
      .b   (term_ext),
      .sum (sum),
      .ovf (ovf)
   );

   // Values the running state and result would take on an accepted beat.
   // Infinite terms still contribute their bits; the consumer ignores the
   // sum whenever a flag is set.
   always_comb begin
      next_inf = inf_s | in_isInf;
      next_ovf = ovf_s | ovf;
      next_cnt = COUNT_BITS'(sat_inc(SAT_MAX_W'(cnt), COUNT_BITS));
   end

   // Result register occupancy. A last beat arriving while the old result is
   // being consumed replaces it on the same edge, so groups run back-to-back.
   always_comb begin
      next_state = state;
      case (state)
         OUT_EMPTY: begin
            if (accept_last) begin
               next_state = OUT_FULL;
            end
         end
         OUT_FULL: begin
            if (accept_last) begin
               next_state = OUT_FULL;
            end else if (out_ready) begin
               next_state = OUT_EMPTY;
            end
         end
         default: next_state = OUT_EMPTY;
      endcase
   end

   // State register for the result register occupancy.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= OUT_EMPTY;
      end else begin
         state <= next_state;
      end
   end

   // Running group state. The last beat of a group clears it on the same edge
   // that publishes the result, so the next beat starts a fresh group.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         acc   <= '0;
         inf_s <= 1'b0;
         ovf_s <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         if (in_last) begin
            acc   <= '0;
            inf_s <= 1'b0;
            ovf_s <= 1'b0;
            cnt   <= '0;
         end else begin
            acc   <= sum;
            inf_s <= next_inf;
            ovf_s <= next_ovf;
            cnt   <= next_cnt;
         end
      end
   end

   // Result payload. It is only loaded by a last beat and otherwise holds,
   // which keeps it stable while the consumer stalls.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_bits     <= '0;
         out_isInf    <= 1'b0;
         out_overflow <= 1'b0;
         out_count    <= '0;
      end else if (accept_last) begin
         out_bits     <= sum;
         out_isInf    <= next_inf;
         out_overflow <= next_ovf;
         out_count    <= next_cnt;
      end
   end

endmodule

// File: tb/tb_linear_fixed_accumulator.sv
// -----------------------------------------------------------------------------
// tb_linear_fixed_accumulator
// Directed bench for linear_fixed_accumulator. Two instances share the input
// stream: one with default widths, one with GUARD = 0 so that signed overflow
// of the accumulator is reachable with two terms.
// -----------------------------------------------------------------------------
module tb_linear_fixed_accumulator;

   logic        clock;
   logic        resetn;
   logic        in_valid;
   logic [33:0] in_bits;
   logic        in_isInf;
   logic        in_last;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [41:0] out_bits;
   logic        out_isInf;
   logic        out_overflow;
   logic [15:0] out_count;

   logic        g0_in_ready;
   logic        g0_out_valid;
   logic [33:0] g0_out_bits;
   logic        g0_out_isInf;
   logic        g0_out_overflow;
   logic [15:0] g0_out_count;

   int checks = 0;
   int errors = 0;

   linear_fixed_accumulator dut (
      .clock        (clock),
      .resetn       (resetn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_bits      (in_bits),
      .in_isInf     (in_isInf),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_bits     (out_bits),
      .out_isInf    (out_isInf),
      .out_overflow (out_overflow),
      .out_count    (out_count)
   );

   linear_fixed_accumulator #(
      .GUARD (0)
   ) dut_g0 (
      .clock        (clock),
      .resetn       (resetn),
      .in_valid     (in_valid),
      .in_ready     (g0_in_ready),
      .in_bits      (in_bits),
      .in_isInf     (in_isInf),
      .in_last      (in_last),
      .out_valid    (g0_out_valid),
      .out_ready    (out_ready),
      .out_bits     (g0_out_bits),
      .out_isInf    (g0_out_isInf),
      .out_overflow (g0_out_overflow),
      .out_count    (g0_out_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Presents one beat, lets it be taken at the next rising edge, then drops
   // in_valid; returns 1 time unit after the edge so outputs can be sampled.
   task automatic applyStimulus(input logic [33:0] bits, input logic inf,
                                input logic last);
      in_valid = 1'b1;
      in_bits  = bits;
      in_isInf = inf;
      in_last  = last;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_isInf = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      resetn    = 1'b0;
      in_valid  = 1'b1;
      in_bits   = 34'h0_0001_0000;
      in_isInf  = 1'b1;
      in_last   = 1'b1;
      out_ready = 1'b1;

      // 1. Reset with a valid last beat offered
      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      in_valid = 1'b0;
      in_isInf = 1'b0;
      in_last  = 1'b0;
      resetn   = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("rst_in_ready",  64'(in_ready),     64'd1);
      checkOutput("rst_valid",     64'(out_valid),    64'd0);
      checkOutput("rst_bits",      64'(out_bits),     64'd0);
      checkOutput("rst_isInf",     64'(out_isInf),    64'd0);
      checkOutput("rst_overflow",  64'(out_overflow), 64'd0);
      checkOutput("rst_count",     64'(out_count),    64'd0);

      // 2. Normal group: 1.0 + 2.0 - 0.5 = 2.5
      applyStimulus(34'h0_0001_0000, 1'b0, 1'b0);
      applyStimulus(34'h0_0002_0000, 1'b0, 1'b0);
      checkOutput("norm_no_early_valid", 64'(out_valid), 64'd0);
      applyStimulus(34'h3_FFFF_8000, 1'b0, 1'b1);
      checkOutput("norm_valid",    64'(out_valid),    64'd1);
      checkOutput("norm_bits",     64'(out_bits),     64'h0_0002_8000);
      checkOutput("norm_count",    64'(out_count),    64'd3);
      checkOutput("norm_isInf",    64'(out_isInf),    64'd0);
      checkOutput("norm_overflow", 64'(out_overflow), 64'd0);
      @(posedge clock);
      #1;
      checkOutput("norm_drained",  64'(out_valid),    64'd0);

      // Single negative term is sign-extended to the accumulator width
      applyStimulus(34'h3_FFFF_8000, 1'b0, 1'b1);
      checkOutput("neg_bits",  64'(out_bits),  64'h3FF_FFFF_8000);
      checkOutput("neg_count", 64'(out_count), 64'd1);

      // 3. Infinity is sticky within its group, bits still added
      applyStimulus(34'h0_0001_0000, 1'b0, 1'b0);
      applyStimulus(34'h0_0001_0000, 1'b1, 1'b0);
      applyStimulus(34'h0_0001_0000, 1'b0, 1'b1);
      checkOutput("inf_isInf", 64'(out_isInf), 64'd1);
      checkOutput("inf_count", 64'(out_count), 64'd3);
      checkOutput("inf_bits",  64'(out_bits),  64'h0_0003_0000);
      applyStimulus(34'h0_0001_0000, 1'b0, 1'b1);
      checkOutput("inf_clear_isInf", 64'(out_isInf), 64'd0);
      checkOutput("inf_clear_bits",  64'(out_bits),  64'h0_0001_0000);
      checkOutput("inf_clear_count", 64'(out_count), 64'd1);
      checkOutput("inf_clear_valid", 64'(out_valid), 64'd1);

      // 4. Two maximum positive terms: wraps with GUARD = 0, fits with GUARD = 8
      applyStimulus(34'h1_FFFF_FFFF, 1'b0, 1'b0);
      applyStimulus(34'h1_FFFF_FFFF, 1'b0, 1'b1);
      checkOutput("ovf_g0_overflow", 64'(g0_out_overflow), 64'd1);
      checkOutput("ovf_g0_bits",     64'(g0_out_bits),     64'h3_FFFF_FFFE);
      checkOutput("ovf_g0_count",    64'(g0_out_count),    64'd2);
      checkOutput("ovf_g8_overflow", 64'(out_overflow),    64'd0);
      checkOutput("ovf_g8_bits",     64'(out_bits),        64'h3_FFFF_FFFE);

      // 5. Backpressure: result held, offered beat refused for 10 cycles
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_bits   = 34'h0_0007_0000;
      in_last   = 1'b1;
      #1;
      checkOutput("bp_in_ready_comb", 64'(in_ready), 64'd0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         checkOutput("bp_in_ready", 64'(in_ready),  64'd0);
         checkOutput("bp_valid",    64'(out_valid), 64'd1);
         checkOutput("bp_bits",     64'(out_bits),  64'h3_FFFF_FFFE);
         checkOutput("bp_count",    64'(out_count), 64'd2);
      end
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
      applyStimulus(34'h0_0003_0000, 1'b0, 1'b1);
      checkOutput("b2b_valid", 64'(out_valid),    64'd1);
      checkOutput("b2b_bits",  64'(out_bits),     64'h0_0003_0000);
      checkOutput("b2b_count", 64'(out_count),    64'd1);
      checkOutput("b2b_ovf",   64'(out_overflow), 64'd0);

      // 6. Reset mid-group discards the partial sum
      applyStimulus(34'h0_0001_0000, 1'b0, 1'b0);
      applyStimulus(34'h0_0001_0000, 1'b0, 1'b0);
      resetn = 1'b0;
      #3;
      resetn = 1'b1;
      #1;
      checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
      applyStimulus(34'h0_0005_0000, 1'b0, 1'b1);
      checkOutput("mid_rst_bits",  64'(out_bits),  64'h0_0005_0000);
      checkOutput("mid_rst_count", 64'(out_count), 64'd1);

      @(posedge clock);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/linear_fixed_accumulator.md
# linear_fixed_accumulator

- Sequential Kulisch-style accumulator directly downstream of the float-to-linear-fixed converter.
- Consumes a stream of two's-complement linear fixed-point terms plus an infinity flag, and sums them exactly into a widened register.
- On the beat marked last, emits one result: full-width sum, sticky infinity, sticky overflow, term count.
- Sits between the per-product conversion stage and the result normalization/rounding stage of the dot-product datapath.

## Interface

Parameters:
- ACC_NON_FRAC, 17, integer bits of each input term, excluding sign
- ACC_FRAC, 16, fractional bits of each input term
- GUARD, 8, extra headroom bits above the input width
- COUNT_BITS, 16, width of the term counter

Derived widths:
- IN_W = 1 + ACC_NON_FRAC + ACC_FRAC
- ACC_W = IN_W + GUARD

Ports:
- clock  in  1  single clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts the beat this cycle
- in_bits  in  IN_W  two's-complement term, binary point ACC_FRAC from the LSB
- in_isInf  in  1  term is infinite
- in_last  in  1  final term of the current group
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes the result
- out_bits  out  ACC_W  two's-complement sum, binary point ACC_FRAC from the LSB
- out_isInf  out  1  some term in the group was infinite
- out_overflow  out  1  signed overflow of ACC_W occurred in the group
- out_count  out  COUNT_BITS  terms in the group, saturating

## Operation

- Accept: a beat is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. It is combinational from out_valid/out_ready only and never depends on in_valid or in_last.
- Running state (not visible at the outputs):
  - acc: ACC_W bits
  - inf_s, ovf_s: sticky flags
  - cnt: COUNT_BITS
- On an accepted beat, compute:
  - sum = acc + sign_extend(in_bits) to ACC_W, wrapping modulo 2^ACC_W
  - ovf = operands have the same sign and sum's sign differs
  - next_inf = inf_s | in_isInf
  - next_ovf = ovf_s | ovf
  - next_cnt = cnt + 1, saturating at all-ones
- Accepted beat with in_last = 0:
  - running state takes the next_* values and sum.
- Accepted beat with in_last = 1:
  - out_bits/out_isInf/out_overflow/out_count take sum/next_inf/next_ovf/next_cnt.
  - out_valid is set.
  - Running state clears to zero the same edge.
- Output register is two-state:
  - EMPTY (out_valid = 0) → FULL on an accepted last beat.
  - FULL with out_ready = 1 and no accepted last beat → EMPTY.
  - FULL with out_ready = 1 and an accepted last beat → stays FULL with the new result (back-to-back).
  - FULL with out_ready = 0: in_ready = 0, so no beat is accepted; all out_* hold stable.
- Infinity and overflow do not alter the wrapped sum; the consumer discards out_bits when either flag is set.
- A single-beat group (first beat also last) yields exactly that term, sign-extended, with count 1.
- in_isInf with arbitrary in_bits: the bits are still added.

## Timing

- Reset (asynchronous assert, synchronous-safe release) forces:
  - out_valid = 0, out_bits = 0, out_isInf = 0, out_overflow = 0, out_count = 0
  - acc, inf_s, ovf_s, cnt all 0
  - in_ready = 1 after reset
- Reset mid-group discards the partial sum; the next accepted beat starts a new group.
- Latency: last beat accepted at edge t → out_valid and result visible after edge t, i.e. in cycle t+1.
- Throughput: one term per cycle while out_ready = 1 or out_valid = 0. No bubble between groups.
- The adder is single-cycle at ACC_W. No internal pipelining.

## Structure

- Shared package kulisch_pkg holds:
  - function for IN_W and ACC_W from ACC_NON_FRAC, ACC_FRAC, GUARD
  - saturating-count helper
  - converter's width constants, so both stages agree
- One sub-module, kulisch_overflow_adder:
  - parameter W
  - inputs a, b; outputs sum, ovf
  - combinational; reused by later multi-lane reduction stages
- Top contains the output-register FSM and the running state.

## Test plan

Defaults: ACC_FRAC = 16, so 1.0 = 0x10000.

1. Reset:
   - Stimulus: assert resetn = 0 with in_valid = 1.
   - Required: out_valid = 0, all out_* = 0, in_ready = 1 after release.
2. Normal group:
   - Stimulus: 0x10000, 0x20000, −0x08000 (last).
   - Required: one cycle later out_valid = 1, out_bits = 0x28000, out_count = 3, out_isInf = 0, out_overflow = 0.
3. Infinity:
   - Stimulus: group 1.0, in_isInf = 1, 1.0 (last).
   - Required: out_isInf = 1, out_count = 3.
   - Then: the next group 1.0 (last) gives out_isInf = 0, out_bits = 0x10000.
4. Overflow:
   - Stimulus: GUARD = 0, two beats of 2^(IN_W−1)−1.
   - Required: out_overflow = 1, out_bits = wrapped value −2.
5. Backpressure:
   - Stimulus: hold out_ready = 0 after a result.
   - Required: in_ready = 0 and out_* stable for 10 cycles.
   - Then: raise out_ready with a single-beat last group of 0x30000 → result replaced same edge, out_valid stays 1, out_bits = 0x30000.
6. Reset mid-group:
   - Stimulus: accept 0x10000, 0x10000, pulse resetn, then 0x50000 (last).
   - Required: out_bits = 0x50000, out_count = 1.
